// File: rtl/shifter_pkg.sv
// Shared definitions for the barrel-shifter command path: function codes and the queued command.
package shifter_pkg;

  localparam logic [3:0] FN_PASS  = 4'b0000;
  localparam logic [3:0] FN_SHL   = 4'b0001;
  localparam logic [3:0] FN_ASR   = 4'b0010;
  localparam logic [3:0] FN_SHL_B = 4'b0011;
  localparam logic [3:0] FN_SHR   = 4'b0100;
  localparam logic [3:0] FN_ROL   = 4'b0101;
  localparam logic [3:0] FN_ROR   = 4'b0110;
  localparam logic [3:0] FN_SHL_C = 4'b0111;
  localparam logic [3:0] FN_SHR_B = 4'b1000;
  localparam logic [3:0] FN_MAX   = 4'b1000;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] amount;
    logic [3:0] func;
  } shift_cmd_t;

  function automatic logic is_illegal_func(input logic [3:0] func);
    return func > FN_MAX;
  endfunction

endpackage

// File: rtl/shift_cmd_queue_if.sv
// Command and result handshakes of the shifter command queue.
interface shift_cmd_queue_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic [2:0] cmd_amount;
  logic [3:0] cmd_func;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [3:0] res_func;

  modport master (
    output cmd_valid, cmd_data, cmd_amount, cmd_func, res_ready,
    input  cmd_ready, res_valid, res_data, res_func
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_amount, cmd_func, res_ready,
    output cmd_ready, res_valid, res_data, res_func
  );
endinterface

// File: rtl/sync_fifo.sv
// Registered-storage FIFO of shift commands; head is read straight from the storage array.
module sync_fifo
  import shifter_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  shift_cmd_t       wdata_i,
  input  logic             pop_i,
  output shift_cmd_t       head_o,
  output logic [LVL_W-1:0] level_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  shift_cmd_t             mem_q [DEPTH];
  logic       [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic       [LVL_W-1:0] level_q, level_d;
  logic                   do_push, do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (do_pop && !do_push) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/shift_cmd_queue.sv
// Command queue in front of the combinational barrel shifter with a registered result slot.
module shift_cmd_queue
  import shifter_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  shift_cmd_queue_if.slave   bus_io,
  output logic [7:0]         sh_data_in_o,
  output logic [2:0]         sh_shift_amount_o,
  output logic [3:0]         sh_shift_function_o,
  input  logic [7:0]         sh_data_out_i,
  output logic               illegal_func_err_o,
  input  logic               err_clr_i,
  output logic [LVL_W-1:0]   fifo_level_o
);

  shift_cmd_t wcmd, head;
  logic       full, empty, issue;
  logic       res_valid_q, res_valid_d;
  logic [7:0] res_data_q, res_data_d;
  logic [3:0] res_func_q, res_func_d;
  logic       err_q, err_d;

  assign wcmd = '{data: bus_io.cmd_data, amount: bus_io.cmd_amount, func: bus_io.cmd_func};

  sync_fifo #(
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (bus_io.cmd_valid),
    .wdata_i (wcmd),
    .pop_i   (issue),
    .head_o  (head),
    .level_o (fifo_level_o),
    .full_o  (full),
    .empty_o (empty)
  );

  assign bus_io.cmd_ready = ~full;
  assign issue            = ~empty & (~res_valid_q | bus_io.res_ready);

  // An empty queue presents a zero PASS command rather than stale storage.
  always_comb begin
    sh_data_in_o        = '0;
    sh_shift_amount_o   = '0;
    sh_shift_function_o = FN_PASS;
    if (!empty) begin
      sh_data_in_o        = head.data;
      sh_shift_amount_o   = head.amount;
      sh_shift_function_o = head.func;
    end
  end

  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_func_d  = res_func_q;
    if (issue) begin
      res_valid_d = 1'b1;
      res_data_d  = sh_data_out_i;
      res_func_d  = head.func;
    end else if (res_valid_q && bus_io.res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  // Set has priority over clear when both land on the same edge.
  always_comb begin
    err_d = err_q;
    if (err_clr_i) err_d = 1'b0;
    if (issue && is_illegal_func(head.func)) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_func_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_func_q  <= res_func_d;
      err_q       <= err_d;
    end
  end

  assign bus_io.res_valid  = res_valid_q;
  assign bus_io.res_data   = res_data_q;
  assign bus_io.res_func   = res_func_q;
  assign illegal_func_err_o = err_q;

endmodule

// File: tb/tb_shift_cmd_queue.sv
// Bench for shift_cmd_queue: directed scenarios plus a randomized run against a queue-based model.
module tb_shift_cmd_queue;
  import shifter_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic [7:0]       sh_data_in;
  logic [2:0]       sh_amt;
  logic [3:0]       sh_fn;
  logic [7:0]       sh_data_out;
  logic             err;
  logic             err_clr = 1'b0;
  logic [LVL_W-1:0] level;
  int               total = 0;
  int               bad = 0;

  shift_cmd_queue_if bus ();

  shift_cmd_queue #(
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) dut (
    .clk_i               (clk),
    .rst_ni              (rst_ni),
    .bus_io              (bus),
    .sh_data_in_o        (sh_data_in),
    .sh_shift_amount_o   (sh_amt),
    .sh_shift_function_o (sh_fn),
    .sh_data_out_i       (sh_data_out),
    .illegal_func_err_o  (err),
    .err_clr_i           (err_clr),
    .fifo_level_o        (level)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [2:0] a,
                                           input logic [3:0] f);
    logic [15:0] t;
    case (f)
      FN_PASS:                  return d;
      FN_SHL, FN_SHL_B, FN_SHL_C: return d << a;
      FN_ASR:                   return $unsigned($signed(d) >>> a);
      FN_SHR, FN_SHR_B:         return d >> a;
      FN_ROL: begin t = {d, d} << a; return t[15:8]; end
      FN_ROR: begin t = {d, d} >> a; return t[7:0]; end
      default:                  return 8'h00;
    endcase
  endfunction

  // Stand-in for the combinational shifter.
  always_comb sh_data_out = ref_shift(sh_data_in, sh_amt, sh_fn);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic v, input logic [7:0] d, input logic [2:0] a,
                           input logic [3:0] f);
    bus.cmd_valid  = v;
    bus.cmd_data   = d;
    bus.cmd_amount = a;
    bus.cmd_func   = f;
  endtask

  task automatic apply_reset();
    drive_cmd(1'b0, 8'h00, 3'd0, 4'h0);
    bus.res_ready = 1'b0;
    err_clr = 1'b0;
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%0b exp=0", bus.res_valid); end
    total++; if (level !== '0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%0b exp=1", bus.cmd_ready); end
    total++; if (bus.res_data !== 8'h00 || bus.res_func !== 4'h0) begin bad++;
      $display("FAIL reset_res got=%0h/%0h exp=0/0", bus.res_data, bus.res_func); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", err); end
  endtask

  task automatic test_single();
    apply_reset();
    bus.res_ready = 1'b1;
    drive_cmd(1'b1, 8'hB4, 3'd2, FN_ROL);
    tick();
    drive_cmd(1'b0, 8'h00, 3'd0, 4'h0);
    total++; if (bus.res_valid !== 1'b0 || level !== LVL_W'(1)) begin bad++;
      $display("FAIL single_after_push got=v%0b/l%0d exp=v0/l1", bus.res_valid, level); end
    total++; if (sh_data_in !== 8'hB4 || sh_amt !== 3'd2 || sh_fn !== FN_ROL) begin bad++;
      $display("FAIL single_sh got=%0h/%0d/%0h exp=b4/2/5", sh_data_in, sh_amt, sh_fn); end
    tick();
    total++; if (bus.res_valid !== 1'b1 || bus.res_data !== 8'hD2 || bus.res_func !== 4'b0101) begin
      bad++; $display("FAIL single_result got=v%0b/%0h/%0h exp=v1/d2/5", bus.res_valid,
                      bus.res_data, bus.res_func); end
    tick();
    total++; if (bus.res_valid !== 1'b0 || bus.res_data !== 8'hD2) begin bad++;
      $display("FAIL single_drain got=v%0b/%0h exp=v0/d2", bus.res_valid, bus.res_data); end
  endtask

  task automatic test_stream();
    int valid_cnt = 0;
    apply_reset();
    bus.res_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) drive_cmd(1'b1, 8'h80, 3'(i), FN_SHR);
      else drive_cmd(1'b0, 8'h00, 3'd0, 4'h0);
      tick();
      total++; if (level > LVL_W'(1)) begin bad++; $display("FAIL stream_level i=%0d got=%0d exp<=1", i, level); end
      if (i >= 1) begin
        if (bus.res_valid === 1'b1) valid_cnt++;
        total++; if (bus.res_valid !== 1'b1 || bus.res_data !== (8'h80 >> (i - 1))) begin bad++;
          $display("FAIL stream_data i=%0d got=v%0b/%0h exp=v1/%0h", i, bus.res_valid,
                   bus.res_data, 8'h80 >> (i - 1)); end
      end
    end
    tick();
    total++; if (valid_cnt != 8 || bus.res_valid !== 1'b0) begin bad++;
      $display("FAIL stream_count got=%0d/v%0b exp=8/v0", valid_cnt, bus.res_valid); end
  endtask

  task automatic test_backpressure_full();
    logic [7:0] d;
    apply_reset();
    bus.res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d = 8'h11 * 8'(i + 1);
      drive_cmd(1'b1, d, 3'd0, FN_PASS);
      if (i == 5) begin
        total++; if (bus.cmd_ready !== 1'b0) begin bad++;
          $display("FAIL full_cmd_ready got=%0b exp=0", bus.cmd_ready); end
      end
      tick();
    end
    drive_cmd(1'b0, 8'h00, 3'd0, 4'h0);
    for (int s = 0; s < 3; s++) begin
      total++; if (level !== LVL_W'(DEPTH) || bus.res_valid !== 1'b1 || bus.res_data !== 8'h11) begin
        bad++; $display("FAIL full_stall s=%0d got=l%0d/v%0b/%0h exp=l4/v1/11", s, level,
                        bus.res_valid, bus.res_data); end
      tick();
    end
    bus.res_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      d = 8'h11 * 8'(k + 1);
      total++; if (bus.res_valid !== 1'b1 || bus.res_data !== d || level !== LVL_W'(4 - k)) begin
        bad++; $display("FAIL full_drain k=%0d got=v%0b/%0h/l%0d exp=v1/%0h/l%0d", k,
                        bus.res_valid, bus.res_data, level, d, 4 - k); end
    end
    tick();
    total++; if (bus.res_valid !== 1'b0 || level !== '0) begin bad++;
      $display("FAIL full_end got=v%0b/l%0d exp=v0/l0", bus.res_valid, level); end
  endtask

  task automatic test_illegal();
    apply_reset();
    bus.res_ready = 1'b1;
    drive_cmd(1'b1, 8'hFF, 3'd1, 4'b1010);
    tick();
    drive_cmd(1'b0, 8'h00, 3'd0, 4'h0);
    tick();
    total++; if (bus.res_data !== 8'h00 || bus.res_func !== 4'b1010 || err !== 1'b1) begin bad++;
      $display("FAIL illegal_first got=%0h/%0h/e%0b exp=0/a/e1", bus.res_data, bus.res_func, err); end
    drive_cmd(1'b1, 8'h5A, 3'd3, 4'b1111);
    tick();
    drive_cmd(1'b0, 8'h00, 3'd0, 4'h0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    total++; if (err !== 1'b1 || bus.res_func !== 4'b1111) begin bad++;
      $display("FAIL illegal_set_wins got=e%0b/%0h exp=e1/f", err, bus.res_func); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL illegal_clear got=%0b exp=0", err); end
  endtask

  task automatic test_idle();
    apply_reset();
    bus.res_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++; if (sh_data_in !== 8'h00 || sh_fn !== 4'h0 || sh_amt !== 3'd0 || bus.res_valid !== 1'b0)
      begin bad++; $display("FAIL idle i=%0d got=%0h/%0d/%0h/v%0b exp=0/0/0/v0", i, sh_data_in,
                            sh_amt, sh_fn, bus.res_valid); end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_cmd(1'b1, 8'(8'hA0 + i), 3'd0, FN_PASS);
      tick();
    end
    drive_cmd(1'b0, 8'h00, 3'd0, 4'h0);
    total++; if (bus.res_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre got=%0b exp=1", bus.res_valid); end
    rst_ni = 1'b0;
    #1;
    total++; if (bus.res_valid !== 1'b0 || level !== '0 || bus.cmd_ready !== 1'b1) begin bad++;
      $display("FAIL midrst_async got=v%0b/l%0d/r%0b exp=v0/l0/r1", bus.res_valid, level,
               bus.cmd_ready); end
    tick();
    rst_ni = 1'b1;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (bus.res_valid !== 1'b0 || level !== '0) begin bad++;
        $display("FAIL midrst_stale i=%0d got=v%0b/l%0d exp=v0/l0", i, bus.res_valid, level); end
    end
  endtask

  task automatic test_random();
    shift_cmd_t q[$];
    shift_cmd_t c, h;
    logic       m_valid, m_err, m_issue, m_push;
    logic [7:0] m_data;
    logic [3:0] m_func;
    apply_reset();
    m_valid = 1'b0; m_err = 1'b0; m_data = 8'h00; m_func = 4'h0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      total++; if (bus.res_valid !== m_valid || bus.res_data !== m_data || bus.res_func !== m_func)
      begin bad++; $display("FAIL rand_res cyc=%0d got=v%0b/%0h/%0h exp=v%0b/%0h/%0h", cyc,
                            bus.res_valid, bus.res_data, bus.res_func, m_valid, m_data, m_func); end
      total++; if (level !== LVL_W'(q.size()) || bus.cmd_ready !== (q.size() != DEPTH) || err !== m_err)
      begin bad++; $display("FAIL rand_state cyc=%0d got=l%0d/r%0b/e%0b exp=l%0d/r%0b/e%0b", cyc,
                            level, bus.cmd_ready, err, q.size(), q.size() != DEPTH, m_err); end
      total++; if (sh_data_in !== (q.size() != 0 ? q[0].data : 8'h00)) begin bad++;
        $display("FAIL rand_sh cyc=%0d got=%0h exp=%0h", cyc, sh_data_in,
                 q.size() != 0 ? q[0].data : 8'h00); end
      c.data   = 8'($urandom);
      c.amount = 3'($urandom);
      c.func   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      drive_cmd(1'($urandom_range(0, 1)), c.data, c.amount, c.func);
      bus.res_ready = (cyc >= 150 && cyc < 250) ? ($urandom_range(0, 4) == 0)
                                                : ($urandom_range(0, 3) != 0);
      err_clr = ($urandom_range(0, 9) == 0);
      m_push  = bus.cmd_valid && (q.size() != DEPTH);
      m_issue = (q.size() != 0) && (!m_valid || bus.res_ready);
      if (m_issue) begin
        h = q.pop_front();
        m_data = ref_shift(h.data, h.amount, h.func);
        m_func = h.func;
        m_valid = 1'b1;
      end else if (m_valid && bus.res_ready) begin
        m_valid = 1'b0;
      end
      if (err_clr) m_err = 1'b0;
      if (m_issue && h.func > FN_MAX) m_err = 1'b1;
      if (m_push) q.push_back(c);
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure_full();
    test_illegal();
    test_idle();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
